// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-in / word-out bundle between the UART receiver and its host.
interface uart_rx_if #(parameter int D_bit = 8);
  logic             s_tick;
  logic             rx_in;
  logic [D_bit-1:0] rx_out;
  logic             rx_done_tick;
  logic             frame_err;
  logic             parity_err;
  modport master (output s_tick, rx_in, input rx_out, rx_done_tick, frame_err, parity_err);
  modport slave  (input s_tick, rx_in, output rx_out, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB-first, mid-bit sampling; optional even parity via UART_RX_PARITY_EN.
module uart_rx #(
  parameter int D_bit     = 8,
  parameter int stop_tick = 16
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t           state_q, state_d;
  logic             sync1_q, rx_s;
  logic [3:0]       tick_q, tick_d, bit_q, bit_d;
  logic [D_bit-1:0] sh_q, sh_d, out_q, out_d;
  logic             done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d, perr_q, perr_d;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= bus.rx_in;
      rx_s    <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    out_d   = out_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        tick_d  = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (bus.s_tick) begin
        if (tick_q == 4'd7) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else tick_d = tick_q + 4'd1;
      end
      DATA: if (bus.s_tick) begin
        if (tick_q == 4'd15) begin
          tick_d = '0;
          sh_d   = D_bit'({rx_s, sh_q} >> 1);
          if (bit_q == 4'(D_bit - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + 4'd1;
        end else tick_d = tick_q + 4'd1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bus.s_tick) begin
        if (tick_q == 4'd15) begin
          tick_d  = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else tick_d = tick_q + 4'd1;
      end
`endif
      STOP: if (bus.s_tick) begin
        if (tick_q == 4'(stop_tick - 1)) begin
          tick_d  = '0;
          out_d   = sh_q;
          ferr_d  = ~rx_s;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          perr_d  = ^{sh_q, par_q};
`endif
        end else tick_d = tick_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.rx_out       = out_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected words queued at send time, checked on each done strobe.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] tc = 2'd0;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [7:0] d; logic fe; logic pe;} exp_t;
  exp_t q[$];
  uart_rx_if #(.D_bit(8)) bus();
  uart_rx #(.D_bit(8), .stop_tick(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) tc <= tc + 2'd1;
  assign bus.s_tick = (tc == 2'd3);
  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe rx_out=%h (no frame expected)", bus.rx_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks += 3;
        if (bus.rx_out !== e.d) begin
          failures++;
          $display("FAIL rx_out got=%h exp=%h", bus.rx_out, e.d);
        end
        if (bus.frame_err !== e.fe) begin
          failures++;
          $display("FAIL frame_err got=%b exp=%b (data %h)", bus.frame_err, e.fe, e.d);
        end
        if (bus.parity_err !== e.pe) begin
          failures++;
          $display("FAIL parity_err got=%b exp=%b (data %h)", bus.parity_err, e.pe, e.d);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b, input int n);
    bus.rx_in = b;
    repeat (n) @(posedge clk);
  endtask
  // Low stop bits are shortened so the line is high again before the receiver re-arms.
  task automatic tx(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0, 64);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, 64);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
    if (stop) drive_bit(1'b1, 64);
    else begin
      drive_bit(1'b0, 44);
      drive_bit(1'b1, 20);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic par, input logic pe);
    exp_t e;
    e.d = d;
    e.fe = ~stop;
    e.pe = pe;
    q.push_back(e);
    tx(d, stop, par);
  endtask
  initial begin
    bus.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_out", bus.rx_out, 8'h00);
    chk("reset_done", {7'd0, bus.rx_done_tick}, 8'h00);
    chk("reset_flags", {6'd0, bus.frame_err, bus.parity_err}, 8'h00);
    rst = 1'b0;
    repeat (64) @(posedge clk);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 20 * 64);
    chk("glitch_rx_out", bus.rx_out, 8'h00);
    send(8'hA5, 1'b1, ^8'hA5, 1'b0);
    drive_bit(1'b1, 64);
    send(8'h3C, 1'b0, ^8'h3C, 1'b0);
    drive_bit(1'b1, 64);
    send(8'h55, 1'b1, ^8'h55, 1'b0);
    drive_bit(1'b1, 64);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 64);
    chk("before_reset_rx_out", bus.rx_out, 8'hFF);
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b0, 64);
    drive_bit(1'b0, 32);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rx_out", bus.rx_out, 8'h00);
    chk("abort_flags", {6'd0, bus.frame_err, bus.parity_err}, 8'h00);
    chk("abort_done", {7'd0, bus.rx_done_tick}, 8'h00);
    bus.rx_in = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (128) @(posedge clk);
    send(8'h7E, 1'b1, ^8'h7E, 1'b0);
    drive_bit(1'b1, 64);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 64);
    send(8'h07, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 64);
`endif
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    chk("pending_frames", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
